// File: rtl/dmem_checker.sv
// dmem_checker: word-addressed data RAM for the single-cycle MIPS core with a
// hardware program-completion check (sticky pass/fail verdict).
// Optional watchdog: define DMEM_WATCHDOG_EN to build the cycle-count timeout.
module dmem_checker #(
  parameter int DEPTH_LOG2   = 6,
  parameter int CHECK_ADDR   = 84,
  parameter int CHECK_DATA   = 7,
  parameter int SCRATCH_ADDR = 80,
  parameter int TIMEOUT      = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [15:0] store_count
);

  localparam int          DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [31:0] RANGE_END  = 32'(4 * DEPTH);
  localparam logic [31:0] CHECK_A    = 32'(CHECK_ADDR);
  localparam logic [31:0] CHECK_D    = 32'(CHECK_DATA);
  localparam logic [31:0] SCRATCH_A  = 32'(SCRATCH_ADDR);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PASS = 2'd1,
    S_FAIL = 2'd2
  } state_t;

  state_t state;

  // RAM is deliberately left out of reset so a frozen image survives reset.
  logic [31:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] index;
  logic                  in_range;
  logic                  aligned;
  logic                  legal;
  logic                  hit_check;
  logic                  hit_scratch;
  logic                  store_run;
  logic                  verdict_pass;
  logic                  verdict_fail;
  logic                  ram_we;

  assign index       = dataadr[DEPTH_LOG2+1:2];
  assign in_range    = (dataadr < RANGE_END);
  assign aligned     = (dataadr[1:0] == 2'b00);
  assign legal       = in_range && aligned;
  assign hit_check   = (dataadr == CHECK_A) && (writedata == CHECK_D);
  assign hit_scratch = (dataadr == SCRATCH_A);
  assign store_run   = memwrite && (state == S_RUN);

  // First matching rule wins: illegal address, check hit, scratch, anything else.
  always_comb begin
    verdict_pass = 1'b0;
    verdict_fail = 1'b0;
    if (store_run) begin
      if (!legal) begin
        verdict_fail = 1'b1;
      end else if (hit_check) begin
        verdict_pass = 1'b1;
      end else if (!hit_scratch) begin
        verdict_fail = 1'b1;
      end
    end
  end

  // Misaligned/out-of-range stores and any store after the verdict leave RAM untouched.
  assign ram_we = store_run && legal;

  // Loads are combinational; a same-cycle store becomes visible after the edge.
  assign readdata = in_range ? mem[index] : 32'd0;

  // RAM write port.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[index] <= writedata;
    end
  end

`ifdef DMEM_WATCHDOG_EN
  localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT - 1);
  logic [31:0] wdog;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT == 0);
`endif

  // Verdict FSM with registered flags and saturating store counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_RUN;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      store_count <= 16'd0;
`ifdef DMEM_WATCHDOG_EN
      wdog        <= 32'd0;
`endif
    end else begin
      case (state)
        S_RUN: begin
          if (memwrite && (store_count != 16'hFFFF)) begin
            store_count <= store_count + 16'd1;
          end
          if (verdict_pass) begin
            state <= S_PASS;
            pass  <= 1'b1;
          end else if (verdict_fail) begin
            state <= S_FAIL;
            fail  <= 1'b1;
`ifdef DMEM_WATCHDOG_EN
          end else if (wdog == WD_LIMIT) begin
            // Watchdog expiry only when no store produced a verdict this edge.
            state   <= S_FAIL;
            fail    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            wdog <= wdog + 32'd1;
`endif
          end
        end
        S_PASS: begin
          state <= S_PASS;
        end
        S_FAIL: begin
          state <= S_FAIL;
        end
        default: begin
          state <= S_FAIL;
          fail  <= 1'b1;
        end
      endcase
    end
  end

  assign done = pass | fail;

endmodule

// File: tb/tb_dmem_checker.sv
// Directed-vector bench for dmem_checker: each cycle the stimulus pushes the
// expected observable state into a queue, and a monitor pops and compares it
// on the following falling edge.
module tb_dmem_checker;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic [15:0] store_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        rd_chk;
    logic [31:0] rd;
    logic        pass;
    logic        fail;
    logic        tmo;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  dmem_checker #(
    .DEPTH_LOG2  (6),
    .CHECK_ADDR  (84),
    .CHECK_DATA  (7),
    .SCRATCH_ADDR(80),
    .TIMEOUT     (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite),
    .dataadr    (dataadr),
    .writedata  (writedata),
    .readdata   (readdata),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .timeout    (timeout),
    .store_count(store_count)
  );

  always #5 clk = ~clk;

  // Monitor: compare the DUT against the oldest expectation on each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.rd_chk) begin
          checks++;
          if (readdata !== e.rd) begin
            failures++;
            $display("FAIL %s readdata: got %h expected %h", e.name, readdata, e.rd);
          end
        end
        checks++;
        if ({pass, fail, done, timeout} !== {e.pass, e.fail, e.pass | e.fail, e.tmo}) begin
          failures++;
          $display("FAIL %s flags p/f/d/t: got %b%b%b%b expected %b%b%b%b", e.name,
                   pass, fail, done, timeout, e.pass, e.fail, e.pass | e.fail, e.tmo);
        end
        checks++;
        if (store_count !== e.cnt) begin
          failures++;
          $display("FAIL %s store_count: got %0d expected %0d", e.name, store_count, e.cnt);
        end
      end
    end
  end

  // One cycle of stimulus; expectations describe the state seen before the next edge.
  task automatic cyc(input string name, input logic rst, input logic we,
                     input logic [31:0] adr, input logic [31:0] dat,
                     input logic rd_chk, input logic [31:0] rd,
                     input logic p, input logic f, input logic t, input logic [15:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    memwrite  = we;
    dataadr   = adr;
    writedata = dat;
    e.name = name; e.rd_chk = rd_chk; e.rd = rd;
    e.pass = p; e.fail = f; e.tmo = t; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    cyc("reset", 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  initial begin
    logic wd;
`ifdef DMEM_WATCHDOG_EN
    wd = 1'b1;
`else
    wd = 1'b0;
`endif
    // Asynchronous reset before any clock edge.
    reset = 1'b1; memwrite = 1'b0; dataadr = 32'd0; writedata = 32'd0;
    #2;
    checks++;
    if ({pass, fail, done, timeout, store_count} !== 20'd0) begin
      failures++;
      $display("FAIL async_reset_init: got %b%b%b%b cnt=%0d expected all zero",
               pass, fail, done, timeout, store_count);
    end

    // Pass sequence: scratch store then check store.
    do_reset();
    cyc("st80_5",   1'b0, 1'b1, 32'd80, 32'd5, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("st84_7",   1'b0, 1'b1, 32'd84, 32'd7, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd1);
    cyc("pass_rd84",1'b0, 1'b0, 32'd84, 32'd0, 1'b1, 32'd7, 1'b1, 1'b0, 1'b0, 16'd2);
    cyc("pass_rd80",1'b0, 1'b1, 32'd80, 32'd9, 1'b1, 32'd5, 1'b1, 1'b0, 1'b0, 16'd2);
    cyc("frozen80", 1'b0, 1'b0, 32'd80, 32'd0, 1'b1, 32'd5, 1'b1, 1'b0, 1'b0, 16'd2);

    // Same-cycle load sees old data; wrong check value fails; later stores ignored.
    do_reset();
    cyc("old_on_st",1'b0, 1'b1, 32'd80, 32'hDEADBEEF, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("new_vis",  1'b0, 1'b0, 32'd80, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 16'd1);
    cyc("st84_3",   1'b0, 1'b1, 32'd84, 32'd3, 1'b1, 32'd7, 1'b0, 1'b0, 1'b0, 16'd1);
    cyc("fail84_3", 1'b0, 1'b1, 32'd84, 32'd7, 1'b1, 32'd3, 1'b0, 1'b1, 1'b0, 16'd2);
    cyc("absorb",   1'b0, 1'b0, 32'd84, 32'd0, 1'b1, 32'd3, 1'b0, 1'b1, 1'b0, 16'd2);

    // Misaligned store: fail, no RAM change; load ignores alignment.
    do_reset();
    cyc("st82",     1'b0, 1'b1, 32'd82, 32'h55, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("mis_fail", 1'b0, 1'b0, 32'd80, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 16'd1);

    // Ordinary store to addr 0 fails but writes RAM.
    do_reset();
    cyc("st0",      1'b0, 1'b1, 32'd0, 32'h11, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("st0_fail", 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 16'd1);

    // Out-of-range store (aliases word 0): fail, RAM unchanged, reads 0.
    do_reset();
    cyc("st256",    1'b0, 1'b1, 32'd256, 32'h22, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("oor_rd",   1'b0, 1'b0, 32'd256, 32'd0, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0, 16'd1);
    cyc("oor_w0",   1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 16'd1);

    // Idle run: watchdog expires after edge TO when built, otherwise RUN persists.
    do_reset();
    for (int k = 0; k <= TO + 4; k++) begin
      cyc("idle", 1'b0, 1'b0, 32'd84, 32'd0, 1'b1, 32'd3, 1'b0,
          wd && (k >= TO), wd && (k >= TO), 16'd0);
    end

    // Check store on the edge where the watchdog would expire: store wins.
    do_reset();
    for (int k = 0; k < TO - 1; k++) begin
      cyc("pre_edge20", 1'b0, 1'b0, 32'd84, 32'd0, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 16'd0);
    end
    cyc("st_edge20",  1'b0, 1'b1, 32'd84, 32'd7, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("pass_edge20",1'b0, 1'b0, 32'd84, 32'd0, 1'b1, 32'd7, 1'b1, 1'b0, 1'b0, 16'd1);
    cyc("pass_hold",  1'b0, 1'b0, 32'd84, 32'd0, 1'b1, 32'd7, 1'b1, 1'b0, 1'b0, 16'd1);

    // Reset raised between edges while in PASS: cleared before any clock edge.
    cyc("mid_reset", 1'b1, 1'b0, 32'd84, 32'd0, 1'b1, 32'd7, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("repass_st", 1'b0, 1'b1, 32'd84, 32'd7, 1'b1, 32'd7, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("repass",    1'b0, 1'b0, 32'd84, 32'd0, 1'b1, 32'd7, 1'b1, 1'b0, 1'b0, 16'd1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, required finish");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/dmem_checker.md
# dmem_checker

Data-memory responder for the single-cycle MIPS `top`; it is the slave end of the processor's `memwrite`/`dataadr`/`writedata` store interface. It holds a word-addressed data RAM, serves combinational loads, and applies the program-completion check in hardware. The check passes when the expected value is stored to the check address, and fails on any other store outside the scratch address. A sticky registered verdict gives self-checking runs on FPGA and in simulation without a behavioural bench.

## Interface
Parameters:
- `DEPTH_LOG2`, 6: RAM holds 2^DEPTH_LOG2 32-bit words.
- `CHECK_ADDR`, 84: byte address whose store ends the run.
- `CHECK_DATA`, 7: value that makes a store to `CHECK_ADDR` a pass.
- `SCRATCH_ADDR`, 80: byte address where stores are permitted without ending the run.
- `TIMEOUT`, 1000: watchdog limit in cycles.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `memwrite`  in  1  store strobe from the core.
- `dataadr`  in  32  byte address from the core.
- `writedata`  in  32  store data.
- `readdata`  out  32  load data, combinational.
- `done`  out  1  verdict reached (`pass | fail`).
- `pass`  out  1  sticky pass.
- `fail`  out  1  sticky fail.
- `timeout`  out  1  fail was caused by the watchdog.
- `store_count`  out  16  stores accepted while in RUN.

## Operation
- Word index is `dataadr[DEPTH_LOG2+1:2]`.
- An address is in range when `dataadr < 4*2^DEPTH_LOG2`. It is aligned when `dataadr[1:0]==0`.
- Loads: `readdata` is `mem[index]` when the address is in range, otherwise 0. Alignment is ignored for loads.
- RAM contents are not reset and are undefined until written.
- FSM states are RUN, PASS and FAIL. Reset enters RUN.
- In RUN, on a rising edge with `memwrite=1`, the first matching rule applies:
  1. Address misaligned or out of range: go to FAIL and suppress the RAM write.
  2. `dataadr==CHECK_ADDR` and `writedata==CHECK_DATA`: write RAM, go to PASS.
  3. `dataadr==SCRATCH_ADDR`: write RAM, stay in RUN.
  4. Otherwise: write RAM, go to FAIL.
- `store_count` increments on every store seen in RUN, including the one that ends the run. It saturates at 0xFFFF.
- PASS and FAIL are absorbing; only `reset` leaves them. In either state, RAM writes are suppressed (frozen image) and `store_count` holds.
- `pass = (state==PASS)` and `fail = (state==FAIL)`. `done = pass | fail`.

## Timing
- Reset values: `pass=0`, `fail=0`, `done=0`, `timeout=0`, `store_count=0`, state RUN, watchdog 0.
- Loads have zero latency: `readdata` follows `dataadr` combinationally, including a RAM word written on the previous edge.
- Verdict latency is one edge. A store sampled at edge N drives `pass`/`fail` high immediately after edge N.
- A store to the same word as a load in the same cycle: the load returns the old data; the new data is visible after the edge.
- `reset` asserted mid-run clears the FSM, the counters and the flags at once, without waiting for a clock. RAM is untouched.
- The first store is accepted on the first rising edge after `reset` falls.

## Configuration
- `DMEM_WATCHDOG_EN` defined:
  - A 32-bit cycle counter runs in RUN, starting from 0 at reset.
  - When it reaches `TIMEOUT-1` with no verdict, the next edge moves to FAIL and sets `timeout=1`.
  - A verdict-producing store on that same edge takes priority, and `timeout` stays 0.
- `DMEM_WATCHDOG_EN` undefined: no counter is built, `timeout` is tied to 0, and RUN can persist indefinitely.

## Test plan
- Reset, then store 5 to addr 80, then store 7 to addr 84 → after the second edge `pass=1`, `done=1`, `fail=0`, `store_count=2`. `readdata` shows 7 at addr 84 and 5 at addr 80.
- Store 3 to addr 84 → `fail=1`, `store_count=1`. A later store of 7 to 84 is ignored: `pass` stays 0, RAM still reads 3, count holds.
- Store to addr 82 (misaligned) or addr 256 (out of range, DEPTH_LOG2=6) → `fail=1` and no RAM change. Reading addr 256 returns 0.
- Write 0xDEADBEEF to addr 80, then drive `dataadr=80` with `memwrite=0` → `readdata=0xDEADBEEF` in the same cycle, with no verdict change.
- With `DMEM_WATCHDOG_EN` and `TIMEOUT=20`: no stores for 20 cycles → `fail=1` and `timeout=1` after the 20th edge. A store of 7 to 84 on edge 20 → `pass=1`, `timeout=0`.
- Assert `reset` asynchronously while in PASS, between clock edges → all flags and `store_count` go to 0 without a clock edge. The next valid pass sequence passes again.
